cordic_result_tx: RTL and testbench

- Output-side transmitter for the CORDIC datapath.
- Accepts fixed-latency, non-stallable results from the output interface and buffers them in a FIFO.
- Re-emits results to the downstream consumer on a valid/ready stream.
- Returns issue credits to the input side so the pipeline can never overrun the buffer.

---
 rtl/cordic_result_tx_pkg.sv | 7 +
 rtl/cordic_tx_fifo.sv | 40 ++++
 rtl/cordic_result_tx.sv | 83 ++++++++
 tb/tb_cordic_result_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cordic_result_tx_pkg.sv
// cordic_result_tx_pkg: Q7.8 result format widths and serializer beat encodings.
package cordic_result_tx_pkg;
    localparam int CORDIC_INT_W  = 7;
    localparam int CORDIC_FRAC_W = 8;
    localparam int CORDIC_OUT_W  = 1 + CORDIC_INT_W + CORDIC_FRAC_W;
    typedef enum logic {BEAT_X = 1'b0, BEAT_Y = 1'b1} beat_e;
endpackage

// File: rtl/cordic_tx_fifo.sv
// cordic_tx_fifo: show-ahead circular FIFO; a push into a full FIFO is accepted only alongside a pop.
module cordic_tx_fifo #(
    parameter int W         = 32,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [W-1:0]         din,
    output logic [W-1:0]         dout,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == CNT_WIDTH'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/cordic_result_tx.sv
// cordic_result_tx: buffers CORDIC results, streams them downstream and returns issue credits.
// CORDIC_TX_SERIAL_EN: send each result as two beats (X then Y) on tx_x instead of one parallel beat.
module cordic_result_tx
    import cordic_result_tx_pkg::*;
#(
    parameter int OUTPUT_WIDTH = CORDIC_OUT_W,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue,
    output logic                    issue_ready,
    input  logic                    res_valid,
    input  logic [OUTPUT_WIDTH-1:0] res_x,
    input  logic [OUTPUT_WIDTH-1:0] res_y,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [OUTPUT_WIDTH-1:0] tx_x,
    output logic [OUTPUT_WIDTH-1:0] tx_y,
    output logic                    tx_last,
    output logic [CNT_WIDTH-1:0]    count,
    output logic [CNT_WIDTH-1:0]    credit,
    input  logic                    clear,
    output logic                    overflow,
    output logic                    credit_err
);
    logic [2*OUTPUT_WIDTH-1:0] head;
    logic [OUTPUT_WIDTH-1:0]   head_x, head_y;
    logic                      full, empty, pop, issue_ok;

    cordic_tx_fifo #(
        .W(2*OUTPUT_WIDTH), .DEPTH(FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)
    ) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(res_valid), .pop(pop),
        .din({res_x, res_y}), .dout(head), .full(full), .empty(empty), .count(count)
    );

    assign head_x      = head[2*OUTPUT_WIDTH-1:OUTPUT_WIDTH];
    assign head_y      = head[OUTPUT_WIDTH-1:0];
    assign tx_valid    = ~empty;
    assign issue_ready = credit != '0;
    assign issue_ok    = issue & issue_ready;

`ifdef CORDIC_TX_SERIAL_EN
    beat_e state, state_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BEAT_X;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (tx_valid & tx_ready) state_nxt = state == BEAT_X ? BEAT_Y : BEAT_X;
        pop     = tx_valid & tx_ready & (state == BEAT_Y);
        tx_x    = ~tx_valid ? '0 : state == BEAT_Y ? head_y : head_x;
        tx_y    = '0;
        tx_last = tx_valid & (state == BEAT_Y);
    end
`else
    always_comb begin
        pop     = tx_valid & tx_ready;
        tx_x    = tx_valid ? head_x : '0;
        tx_y    = tx_valid ? head_y : '0;
        tx_last = tx_valid;
    end
`endif

    // Credit saturates at FIFO_DEPTH so pops of unaccounted results cannot wrap it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit     <= CNT_WIDTH'(FIFO_DEPTH);
            overflow   <= 1'b0;
            credit_err <= 1'b0;
        end else begin
            if (issue_ok & ~pop)
                credit <= credit - CNT_WIDTH'(1);
            else if (pop & ~issue_ok & (credit < CNT_WIDTH'(FIFO_DEPTH)))
                credit <= credit + CNT_WIDTH'(1);
            overflow   <= (overflow & ~clear) | (res_valid & full & ~pop);
            credit_err <= (credit_err & ~clear) | (issue & ~issue_ready);
        end
    end
endmodule

// File: tb/tb_cordic_result_tx.sv
// tb_cordic_result_tx: vector table, directed corner sequences and a randomized run against a queue model.
module tb_cordic_result_tx;
`ifdef CORDIC_TX_SERIAL_EN
    localparam bit SERIAL = 1'b1;
`else
    localparam bit SERIAL = 1'b0;
`endif
    localparam int BEATS = SERIAL ? 2 : 1;
    localparam int LAT   = 5;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        issue = 1'b0, res_valid = 1'b0, tx_ready = 1'b0, clear = 1'b0;
    logic [15:0] res_x = '0, res_y = '0;
    logic        issue_ready, tx_valid, tx_last, overflow, credit_err;
    logic [15:0] tx_x, tx_y;
    logic [3:0]  count, credit;
    int          pass_cnt = 0, total_cnt = 0;

    cordic_result_tx dut (
        .clk(clk), .rst_n(rst_n), .issue(issue), .issue_ready(issue_ready),
        .res_valid(res_valid), .res_x(res_x), .res_y(res_y),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_x(tx_x), .tx_y(tx_y), .tx_last(tx_last),
        .count(count), .credit(credit), .clear(clear), .overflow(overflow), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        issue, res_v, clr;
        logic [15:0] x, y;
        logic [3:0]  e_count, e_credit;
        logic        e_valid, e_ovf, e_cerr;
    } vec_t;
    vec_t tbl[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic i, input logic rv, input logic [15:0] x, input logic [15:0] y,
                         input logic rdy, input logic clr);
        issue = i; res_valid = rv; res_x = x; res_y = y; tx_ready = rdy; clear = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [31:0] q[$];
    logic        pv[LAT];
    logic [31:0] pd[LAT];
    logic [3:0]  m_cred;
    logic        m_ovf, m_cerr, m_phase, m_pop, m_iok;
    logic [15:0] e_x, e_y;
    logic [31:0] hd;
    int          inflight;

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0, 4'(7 - i), 1'b0, 1'b0, 1'b0};
        for (int j = 0; j < 8; j++)
            tbl[8 + j] = '{1'b0, 1'b1, 1'b0, 16'(16'h1000 + j), 16'(16'hF000 - j), 4'(j + 1), 4'd0, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 4'd8, 4'd0, 1'b1, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 16'hDEAD, 16'hBEEF, 4'd8, 4'd0, 1'b1, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 4'd8, 4'd0, 1'b1, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0};

        do_reset();
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_credit", 32'(credit), 8);
        chk("rst_issue_ready", 32'(issue_ready), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_flags", {tx_last, overflow, credit_err}, 0);
        chk("rst_data", {tx_x, tx_y}, 0);

        // Backpressure, credit exhaustion, overflow and clear-vs-event priority.
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].issue, tbl[i].res_v, tbl[i].x, tbl[i].y, 1'b0, tbl[i].clr);
            step();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("vec%0d_credit", i), {credit, 3'b0, issue_ready}, {tbl[i].e_credit, 3'b0, tbl[i].e_credit != 0});
            chk($sformatf("vec%0d_flags", i), {tx_valid, overflow, credit_err}, {tbl[i].e_valid, tbl[i].e_ovf, tbl[i].e_cerr});
        end
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++)
            for (int b = 0; b < BEATS; b++) begin
                e_x = (SERIAL && b == 1) ? 16'(16'hF000 - i) : 16'(16'h1000 + i);
                e_y = SERIAL ? 16'h0 : 16'(16'hF000 - i);
                chk($sformatf("drain%0d_%0d", i, b), {tx_valid, tx_last, tx_x, tx_y}, {1'b1, b == BEATS - 1, e_x, e_y});
                step();
            end
        chk("drain_end", {tx_valid, count, credit}, {1'b0, 4'd0, 4'd8});

        // Single result latency and credit return.
        do_reset();
        drive(1, 0, 0, 0, 1, 0);
        step();
        drive(0, 1, 16'h0100, 16'hFF00, 1, 0);
        step();
        drive(0, 0, 0, 0, 1, 0);
        chk("single_valid", 32'(tx_valid), 1);
        chk("single_x", 32'(tx_x), 32'h0100);
`ifdef CORDIC_TX_SERIAL_EN
        chk("single_last0", 32'(tx_last), 0);
        step();
        chk("single_beat_y", {tx_x, tx_y, 15'b0, tx_last}, {16'hFF00, 16'h0, 16'h1});
`else
        chk("single_y", {tx_y, 15'b0, tx_last}, {16'hFF00, 16'h1});
`endif
        step();
        chk("single_done", {count, credit}, {4'd0, 4'd8});

`ifdef CORDIC_TX_SERIAL_EN
        // Stalled beats hold; pop and credit return only after the Y beat.
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        step();
        drive(0, 1, 16'h1234, 16'h5678, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("ser_x0", {tx_x, 14'b0, tx_valid, tx_last}, {16'h1234, 16'h2});
        step();
        chk("ser_hold_x", {tx_x, 7'b0, tx_last, count, credit}, {16'h1234, 8'h0, 4'd1, 4'd7});
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("ser_y", {tx_x, 7'b0, tx_last, count, credit}, {16'h5678, 8'h1, 4'd1, 4'd7});
        step();
        chk("ser_hold_y", {tx_x, 7'b0, tx_last, count, credit}, {16'h5678, 8'h1, 4'd1, 4'd7});
        tx_ready = 1'b1;
        step();
        chk("ser_done", {tx_valid, count, credit}, {1'b0, 4'd0, 4'd8});
`endif

        // Issue and pop together leave credit alone; push into full FIFO with a pop is accepted.
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        repeat (5) step();
        drive(0, 1, 16'h0A0A, 16'h0B0B, 0, 0);
        repeat (2) step();
        chk("pre_both", {count, credit}, {4'd2, 4'd3});
`ifdef CORDIC_TX_SERIAL_EN
        drive(0, 0, 0, 0, 1, 0);
        step();
`endif
        drive(1, 0, 0, 0, 1, 0);
        step();
        chk("issue_pop_same", {count, credit}, {4'd1, 4'd3});
        drive(0, 1, 16'h0C0C, 16'h0D0D, 0, 0);
        repeat (7) step();
        chk("refill_full", 32'(count), 8);
`ifdef CORDIC_TX_SERIAL_EN
        drive(0, 0, 0, 0, 1, 0);
        step();
`endif
        drive(0, 1, 16'h0E0E, 16'h0F0F, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("full_push_pop", {count, credit, 3'b0, overflow}, {4'd8, 4'd4, 4'd0});

        // Randomized run against a pipeline-latency queue model.
        do_reset();
        q.delete();
        for (int k = 0; k < LAT; k++) begin pv[k] = 1'b0; pd[k] = '0; end
        m_cred = 4'd8; m_ovf = 1'b0; m_cerr = 1'b0; m_phase = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 2) != 0, pv[LAT-1], pd[LAT-1][31:16], pd[LAT-1][15:0],
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            hd  = q.size() != 0 ? q[0] : 32'h0;
            e_x = (SERIAL && m_phase) ? hd[15:0] : hd[31:16];
            e_y = SERIAL ? 16'h0 : hd[15:0];
            chk($sformatf("rand%0d_out", c), {tx_valid, tx_last, issue_ready, tx_x, tx_y},
                {q.size() != 0, q.size() != 0 && (!SERIAL || m_phase), m_cred != 0, e_x, e_y});
            m_iok = issue && m_cred != 0;
            m_pop = q.size() != 0 && tx_ready && (!SERIAL || m_phase);
            if (q.size() != 0 && tx_ready) m_phase = SERIAL ? ~m_phase : 1'b0;
            if (m_pop) void'(q.pop_front());
            m_ovf  = (m_ovf & ~clear) | (res_valid && q.size() >= 8);
            m_cerr = (m_cerr & ~clear) | (issue && m_cred == 0);
            if (res_valid && q.size() < 8) q.push_back({res_x, res_y});
            if (m_iok && !m_pop) m_cred--;
            else if (m_pop && !m_iok && m_cred < 8) m_cred++;
            step();
            for (int k = LAT - 1; k > 0; k--) begin pv[k] = pv[k-1]; pd[k] = pd[k-1]; end
            pv[0] = m_iok;
            pd[0] = $urandom;
            inflight = 0;
            for (int k = 0; k < LAT; k++) inflight += int'(pv[k]);
            chk($sformatf("rand%0d_state", c), {count, credit, 6'b0, overflow, credit_err},
                {4'(q.size()), m_cred, 6'b0, m_ovf, m_cerr});
            chk($sformatf("rand%0d_invariant", c), 32'(int'(credit) + int'(count) + inflight), 8);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
